// File: rtl/regfile_pkg.sv
// Shared constants and FSM encoding for the multi-port register file.
// Pure declarations: no latency, no backpressure.
package regfile_pkg;

    localparam bit Enabled   = 1'b1;
    localparam bit Disabled  = 1'b0;
    localparam int Zero      = 0;

    localparam int DW_DEF    = 32;
    localparam int AW_DEF    = 5;
    localparam int DEPTH_DEF = 32;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Bundles the read/write ports of regfile_mp; master = decode/writeback side.
// Wires only: no latency; upstream stalls while init_busy is high.
interface regfile_mp_if import regfile_pkg::*; #(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    parameter int NR = 2,
    parameter int NW = 1
);

    logic [NW-1:0]    we;
    logic [NW*AW-1:0] waddr;
    logic [NW*DW-1:0] wdata;
    logic [NR-1:0]    re;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic             init_busy;

    modport master (
        output we, waddr, wdata, re, raddr,
        input  rdata, init_busy
    );

    modport slave (
        input  we, waddr, wdata, re, raddr,
        output rdata, init_busy
    );

endinterface

// File: rtl/regfile_init_ctrl.sv
// Post-reset clear sequencer: walks every entry once, emitting a zero write per cycle.
// DEPTH cycles from reset release to RUN; init_busy tells the parent to block user traffic.
module regfile_init_ctrl import regfile_pkg::*; #(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    output logic          clr_we_o,
    output logic [AW-1:0] clr_addr_o,
    output logic          init_busy_o
);

    localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_we_o = 1'b0;
        if (state_q == INIT) begin
            // Reset owns the edge it is asserted on; the array is left alone then.
            clr_we_o = !rst;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LastAddr) begin
                state_d = RUN;
                cnt_d   = '0;
            end
        end
    end

    assign clr_addr_o  = cnt_q;
    assign init_busy_o = (state_q == INIT);

endmodule

// File: rtl/regfile_mp.sv
// NR-read / NW-write register file with hardware clear after reset; optional forwarding via REGFILE_BYPASS_EN.
// Reads are registered (1 cycle); all traffic is ignored while init_busy is high.
module regfile_mp import regfile_pkg::*; #(
    parameter int DW       = DW_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int AW       = AW_DEF,
    parameter int NR       = 2,
    parameter int NW       = 1,
    parameter bit ZERO_REG = Enabled
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);

    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          init_busy;
    logic          run;

    logic [NW-1:0]    wr_en;
    logic [DW-1:0]    regs_q [DEPTH];
    logic [DW-1:0]    regs_d [DEPTH];
    logic [NR*DW-1:0] rd_val;
    logic [NR*DW-1:0] rdata_q, rdata_d;

    function automatic logic writable(input logic [AW-1:0] a);
        return (32'(a) < 32'(DEPTH)) && !(ZERO_REG && (a == AW'(Zero)));
    endfunction

    regfile_init_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_init_ctrl (
        .clk         (clk),
        .rst         (rst),
        .clr_we_o    (clr_we),
        .clr_addr_o  (clr_addr),
        .init_busy_o (init_busy)
    );

    assign run = !init_busy && !rst;

    always_comb begin
        wr_en = '0;
        for (int i = 0; i < NW; i++) begin
            wr_en[i] = bus.we[i] && run && writable(bus.waddr[i*AW +: AW]);
        end
    end

    // Ascending port loop: the last matching (highest-index) write wins.
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            regs_d[r] = regs_q[r];
            if (clr_we && (clr_addr == AW'(r))) begin
                regs_d[r] = '0;
            end
            for (int i = 0; i < NW; i++) begin
                if (wr_en[i] && (bus.waddr[i*AW +: AW] == AW'(r))) begin
                    regs_d[r] = bus.wdata[i*DW +: DW];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    // Out-of-range addresses match no row and so read as zero.
    always_comb begin
        rd_val = '0;
        for (int p = 0; p < NR; p++) begin
            for (int r = 0; r < DEPTH; r++) begin
                if (bus.raddr[p*AW +: AW] == AW'(r)) begin
                    rd_val[p*DW +: DW] = regs_q[r];
                end
            end
`ifdef REGFILE_BYPASS_EN
            for (int i = 0; i < NW; i++) begin
                if (wr_en[i] && (bus.waddr[i*AW +: AW] == bus.raddr[p*AW +: AW])) begin
                    rd_val[p*DW +: DW] = bus.wdata[i*DW +: DW];
                end
            end
`endif
            if (ZERO_REG && (bus.raddr[p*AW +: AW] == AW'(Zero))) begin
                rd_val[p*DW +: DW] = '0;
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        for (int p = 0; p < NR; p++) begin
            if (bus.re[p] && !init_busy) begin
                rdata_d[p*DW +: DW] = rd_val[p*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign bus.rdata     = rdata_q;
    assign bus.init_busy = init_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed + random bench for regfile_mp (NR=2, NW=2, DEPTH=32, ZERO_REG=1).
// Expected read data is queued when a cycle is driven and compared one edge later.
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int NR    = 2;
    localparam int NW    = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    regfile_mp_if #(.DW(DW), .AW(AW), .NR(NR), .NW(NW)) bus ();

    regfile_mp #(
        .DW       (DW),
        .DEPTH    (DEPTH),
        .AW       (AW),
        .NR       (NR),
        .NW       (NW),
        .ZERO_REG (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string         tag;
        int            port;
        logic [DW-1:0] val;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] mdl  [DEPTH];
    logic [DW-1:0] last [NR];
    int            busy_left = 0;
    int            busy_seen = 0;
    int            tests     = 0;
    int            fails     = 0;

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        if (a == '0) return '0;
        v = mdl[a];
`ifdef REGFILE_BYPASS_EN
        for (int i = 0; i < NW; i++) begin
            if (bus.we[i] && (bus.waddr[i*AW +: AW] == a)) v = bus.wdata[i*DW +: DW];
        end
`endif
        return v;
    endfunction

    task automatic idle();
        bus.we    = '0;
        bus.waddr = '0;
        bus.wdata = '0;
        bus.re    = '0;
        bus.raddr = '0;
    endtask

    task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.we[i]             = 1'b1;
        bus.waddr[i*AW +: AW] = a;
        bus.wdata[i*DW +: DW] = d;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        bus.re[p]             = 1'b1;
        bus.raddr[p*AW +: AW] = a;
    endtask

    task automatic step(input string tag);
        exp_t          e;
        logic          run_edge;
        logic          exp_busy;
        logic [DW-1:0] obs;
        run_edge = !rst && (busy_left == 0);
        for (int p = 0; p < NR; p++) begin
            if (rst) last[p] = '0;
            else if (run_edge && bus.re[p]) last[p] = model_read(bus.raddr[p*AW +: AW]);
            e.tag  = tag;
            e.port = p;
            e.val  = last[p];
            sb.push_back(e);
        end
        @(posedge clk);
        if (rst) begin
            busy_left = DEPTH;
        end else if (busy_left > 0) begin
            mdl[DEPTH - busy_left] = '0;
            busy_left--;
        end else begin
            for (int i = 0; i < NW; i++) begin
                if (bus.we[i] && (bus.waddr[i*AW +: AW] != '0))
                    mdl[bus.waddr[i*AW +: AW]] = bus.wdata[i*DW +: DW];
            end
        end
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = bus.rdata[e.port*DW +: DW];
            tests++;
            assert (obs === e.val) else begin
                fails++;
                $error("FAIL %s rdata[%0d] observed=%h expected=%h", e.tag, e.port, obs, e.val);
            end
        end
        exp_busy = (busy_left != 0);
        tests++;
        assert (bus.init_busy === exp_busy) else begin
            fails++;
            $error("FAIL %s init_busy observed=%b expected=%b", tag, bus.init_busy, exp_busy);
        end
        if (bus.init_busy === 1'b1) busy_seen++;
    endtask

    task automatic check_busy_len(input string tag);
        tests++;
        assert (busy_seen === DEPTH) else begin
            fails++;
            $error("FAIL %s busy_cycles observed=%0d expected=%0d", tag, busy_seen, DEPTH);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int p = 0; p < NR; p++) last[p] = '0;
        rst = 1'b1;
        idle();
        step("reset");
        busy_seen = 0;
        step("reset2");
        rst = 1'b0;

        // Traffic during the clear sequence must be ignored.
        for (int c = 0; c < DEPTH; c++) begin
            idle();
            set_wr(0, AW'(c), 32'hFFFF_0000 | c);
            set_wr(1, AW'(c + 1), 32'h0BAD_0000 | c);
            set_rd(0, AW'(c));
            set_rd(1, AW'(c));
            step("init");
        end
        check_busy_len("init_len");

        for (int a = 0; a < DEPTH; a++) begin
            idle();
            set_rd(0, AW'(a));
            set_rd(1, AW'(a + 16));
            step("clear_read");
        end

        idle(); set_wr(0, 5, 32'h0000_AAAA); set_wr(1, 5, 32'h0000_5555); step("dual_wr");
        idle(); set_rd(0, 5); set_rd(1, 5); step("dual_rd");

        idle(); set_wr(0, 7, 32'h0000_DEAD); set_rd(0, 7); set_rd(1, 7); step("rw_same");
        idle(); set_rd(0, 7); step("reread");

        idle(); set_wr(0, 8, 32'h1111_0001); set_wr(1, 8, 32'h2222_0002); set_rd(1, 8); step("byp_prio");
        idle(); set_rd(0, 8); step("prio_rd");

        idle(); set_wr(0, 0, 32'h0000_1234); set_wr(1, 0, 32'h0000_4321);
        set_rd(0, 0); set_rd(1, 0); step("zero_wr");
        idle(); set_rd(0, 0); set_rd(1, 0); step("zero_rd");

        idle(); set_wr(0, 9, 32'h0000_1111); step("hold_wr");
        idle(); set_rd(1, 9); step("hold_pre");
        for (int k = 0; k < 3; k++) begin
            idle(); set_wr(1, 9, 32'h0000_2222 + k); set_rd(0, 9); step("hold");
        end
        idle(); set_rd(1, 9); step("hold_release");

        for (int c = 0; c < 80; c++) begin
            idle();
            for (int i = 0; i < NW; i++)
                if ($urandom_range(0, 1) == 1) set_wr(i, AW'($urandom_range(0, 7)), $urandom);
            for (int p = 0; p < NR; p++)
                if ($urandom_range(0, 3) != 0) set_rd(p, AW'($urandom_range(0, 7)));
            step("rand");
        end

        idle(); set_wr(0, 3, 32'h0000_0077); step("a3_wr");
        idle(); set_rd(0, 3); step("a3_pre");
        idle(); rst = 1'b1; busy_seen = 0; step("rst_run");
        rst = 1'b0;
        for (int c = 0; c < DEPTH; c++) begin
            idle(); set_rd(0, 3); step("reinit");
        end
        check_busy_len("reinit_len");
        idle(); set_rd(0, 3); set_rd(1, 3); step("a3_post");

        idle(); set_wr(1, 12, 32'hCAFE_F00D); step("mid_wr");
        rst = 1'b1; step("rst_a");
        rst = 1'b0;
        for (int c = 0; c < 10; c++) step("init_part");
        rst = 1'b1; busy_seen = 0; step("rst_mid_init");
        rst = 1'b0;
        for (int c = 0; c < DEPTH; c++) step("init_restart");
        check_busy_len("restart_len");
        idle(); set_rd(0, 12); set_rd(1, 5); step("after_restart");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file; successor to the single-write/dual-read register file in the decode stage.
- Supports NR registered read ports and NW write ports.
- Optional hardwired-zero register 0.
- After reset, a hardware clear sequencer zeroes every entry before the file accepts traffic.
- Sits between decode (reads) and writeback (writes); the superscalar issue path uses NR=4, NW=2.

Parameters:
- DW, 32, data width per register
- DEPTH, 32, number of registers
- AW, 5, address width; DEPTH <= 2**AW
- NR, 2, number of read ports
- NW, 1, number of write ports
- ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- we  in  NW  per-port write enable
- waddr  in  NW*AW  write addresses; port i occupies bits [i*AW +: AW]
- wdata  in  NW*DW  write data; port i occupies bits [i*DW +: DW]
- re  in  NR  per-port read enable
- raddr  in  NR*AW  read addresses, packed the same way as waddr
- rdata  out  NR*DW  registered read data, packed the same way as wdata
- init_busy  out  1  high while the clear sequence runs; upstream must stall

Behaviour:
- Reset (rst=1 at a clk edge): all rdata <= 0; init_busy <= 1; FSM -> INIT; clear counter <= 0. Array contents are not touched directly by reset.
- FSM INIT:
  - Each cycle writes 0 to regs[cnt] and increments cnt.
  - When cnt == DEPTH-1 is written, next state is RUN and init_busy <= 0 on the same edge.
  - Takes exactly DEPTH cycles after rst is released.
  - In INIT, we and re are ignored and rdata holds 0.
- FSM RUN:
  - Normal operation; stays in RUN until rst.
  - rst asserted mid-operation or mid-INIT restarts INIT from cnt=0.
- Read:
  - 1-cycle latency: rdata[p] updates on the edge after re[p]=1 is sampled.
  - re[p]=0 holds the previous rdata[p].
  - Each port is independent; any number of ports may read the same address.
- Write: takes effect at the clk edge when we[i]=1.
- Same-address writes in one cycle: the highest port index wins; lower ports are dropped.
- Out-of-range addresses (addr >= DEPTH): writes are discarded; reads return 0.
- ZERO_REG=1: writes to address 0 are discarded; reads of address 0 return 0 regardless of bypass.
- Read/write same address, same cycle, without bypass: read-first (old value returned).
- Width rules: address comparisons use the full AW bits; no truncation or aliasing.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined:
  - Write-first forwarding. A read whose address matches an enabled in-range write in the same cycle returns that wdata.
  - If several writes match, the highest port index wins, consistent with the write priority above.
  - Forwarding is suppressed for address 0 when ZERO_REG=1, and during INIT.
- Undefined: read-first; no forwarding muxes are generated.

Decomposition:
- Shared package regfile_pkg: constants Enabled/Disabled, Zero, default DW/AW/DEPTH, and FSM state encoding (INIT=1'b0, RUN=1'b1).
- Natural sub-module regfile_init_ctrl:
  - Contains the FSM and the clear counter.
  - Outputs clr_we, clr_addr and init_busy.
  - Parent muxes these ahead of the user write ports.

Test Plan:
- Reset then idle, DEPTH=32: init_busy high for exactly 32 cycles after rst falls. Afterwards, reading all 32 addresses on every port returns 0.
- RUN, NW=2: port0 and port1 both write addr 5 (0xAAAA and 0x5555) in the same cycle. A read of 5 next cycle returns 0x5555.
- Write 0xDEAD to addr 7 and read addr 7 in the same cycle:
  - with REGFILE_BYPASS_EN, rdata = 0xDEAD one cycle later;
  - without it, rdata = the old value (0).
  - A re-read the following cycle returns 0xDEAD in both builds.
- ZERO_REG=1: write 0x1234 to addr 0, then read addr 0 on every port, with and without same-cycle bypass. Result is 0.
- rst pulsed while in RUN after addr 3 holds 0x77: INIT restarts with init_busy=1 for 32 cycles. A read of addr 3 afterwards returns 0.
- Hold: re[1]=0 for 3 cycles while addr being read is overwritten. rdata[1] is unchanged until re[1]=1 is reasserted.
